hazard_scoreboard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the integer pipeline.
- Computes per-operand forward selects for the instruction in EX from N younger pipeline stages plus a long-latency (mul/div) result bus.
- Tracks outstanding long-latency writebacks in a register scoreboard and raises stall on load-use or pending-register hazards.
- Keeps a consecutive-stall counter with timeout flag for debug and perf.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/hazard_scoreboard_if.sv | 26 ++
 rtl/fwd_operand_sel.sv | 55 +++++
 rtl/hazard_scoreboard_unit.sv | 143 ++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the integer core.
// Holds the default pipeline geometry, the register-index type, the
// forward-select encoding and the per-register scoreboard vector type.
package cpu_types_pkg;

  localparam int NUM_SRC_DEF         = 2;
  localparam int NUM_FWD_STAGES_DEF  = 2;
  localparam int REG_ADDR_W_DEF      = 5;
  localparam int MAX_OUTSTANDING_DEF = 4;
  localparam int STALL_CNT_W_DEF     = 8;
  localparam int STALL_TIMEOUT_DEF   = 200;
  localparam int SEL_W_DEF           = $clog2(NUM_FWD_STAGES_DEF + 2);

  typedef logic [REG_ADDR_W_DEF-1:0] regbits_t;

  // FWD_STG is the select for stage 0; stage k uses FWD_STG + k.
  typedef enum logic [SEL_W_DEF-1:0] {
    FWD_RF  = SEL_W_DEF'(0),
    FWD_STG = SEL_W_DEF'(1),
    FWD_LAT = SEL_W_DEF'(NUM_FWD_STAGES_DEF + 1)
  } fwd_sel_t;

  typedef logic [(1 << REG_ADDR_W_DEF)-1:0] scoreboard_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side view of the hazard/forwarding unit.
// Carries the EX operand indices, forwarding-stage writer info, the
// long-latency completion bus and the resulting stall.
// Modport hz: the hazard unit's side (inputs from pipeline, stall out).
interface hazard_scoreboard_if #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W     = 5
);

  logic [NUM_SRC*REG_ADDR_W-1:0]        ex_rs;
  logic                                 ex_valid;
  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stg_dest;
  logic [NUM_FWD_STAGES-1:0]            stg_regwr;
  logic [NUM_FWD_STAGES-1:0]            stg_data_valid;
  logic                                 lat_done;
  logic [REG_ADDR_W-1:0]                lat_done_dest;
  logic                                 stall;

  modport hz (
    input  ex_rs, ex_valid, stg_dest, stg_regwr, stg_data_valid,
           lat_done, lat_done_dest,
    output stall
  );

endinterface

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding priority match.
// Ports:
//   rs, ex_valid          operand register index and EX-valid qualifier
//   stg_*                 per-stage destination, write enable, data ready
//   lat_done(_dest)       long-latency result bus this cycle
//   pending               scoreboard bit for rs
//   sel                   0 = regfile, k+1 = stage k, NUM_FWD_STAGES+1 = lat bus
//   hazard                operand cannot be supplied this cycle
module fwd_operand_sel
  import cpu_types_pkg::*;
#(
  parameter int NUM_FWD_STAGES = NUM_FWD_STAGES_DEF,
  parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 2)
) (
  input  logic [REG_ADDR_W-1:0]                rs,
  input  logic                                 ex_valid,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stg_dest,
  input  logic [NUM_FWD_STAGES-1:0]            stg_regwr,
  input  logic [NUM_FWD_STAGES-1:0]            stg_data_valid,
  input  logic                                 lat_done,
  input  logic [REG_ADDR_W-1:0]                lat_done_dest,
  input  logic                                 pending,
  output logic [SEL_W-1:0]                     sel,
  output logic                                 hazard
);

  localparam logic [SEL_W-1:0] SEL_LAT = SEL_W'(NUM_FWD_STAGES + 1);

  logic hit;

  always_comb begin
    sel    = SEL_W'(FWD_RF);
    hazard = 1'b0;
    hit    = 1'b0;
    if (ex_valid && (rs != '0)) begin
      // Youngest matching stage wins; older stages hold stale values.
      for (int k = 0; k < NUM_FWD_STAGES; k++) begin
        if (!hit && stg_regwr[k] && (stg_dest[k*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
          hit    = 1'b1;
          sel    = SEL_W'(k + 1);
          hazard = ~stg_data_valid[k];
        end
      end
      if (!hit) begin
        if (lat_done && (lat_done_dest == rs)) begin
          sel = SEL_LAT;
        end else if (pending) begin
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding and hazard unit for the integer pipeline.
// Selects forward sources for each EX operand, tracks in-flight
// long-latency writebacks in a per-register scoreboard, stalls on
// load-use or pending-register hazards, and counts consecutive stalls.
// Ports:
//   CLK, RST            clock, async active-high reset
//   ex_rs, ex_valid     EX instruction operands
//   stg_*               forwarding stage writers (0 = EX/MEM youngest)
//   lat_issue*          long-latency issue request / accept
//   lat_done*           long-latency completion bus
//   fwd_sel, stall      same-cycle forward selects and pipeline hold
//   outstanding         in-flight long-latency op count
//   hazard_timeout      sticky: consecutive stalls reached the limit
//   sb_error            sticky: completion for a non-pending register
module hazard_scoreboard_unit
  import cpu_types_pkg::*;
#(
  parameter int NUM_SRC         = NUM_SRC_DEF,
  parameter int NUM_FWD_STAGES  = NUM_FWD_STAGES_DEF,
  parameter int REG_ADDR_W      = REG_ADDR_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int STALL_CNT_W     = STALL_CNT_W_DEF,
  parameter int STALL_TIMEOUT   = STALL_TIMEOUT_DEF,
  localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 2),
  localparam int OUT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]        ex_rs,
  input  logic                                 ex_valid,
  input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stg_dest,
  input  logic [NUM_FWD_STAGES-1:0]            stg_regwr,
  input  logic [NUM_FWD_STAGES-1:0]            stg_data_valid,
  input  logic                                 lat_issue,
  input  logic [REG_ADDR_W-1:0]                lat_issue_dest,
  output logic                                 lat_issue_ready,
  input  logic                                 lat_done,
  input  logic [REG_ADDR_W-1:0]                lat_done_dest,
  output logic [NUM_SRC*SEL_W-1:0]             fwd_sel,
  output logic                                 stall,
  output logic [OUT_W-1:0]                     outstanding,
  output logic                                 hazard_timeout,
  output logic                                 sb_error
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [OUT_W-1:0]       OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [STALL_CNT_W-1:0] TIMEOUT_CNT = STALL_CNT_W'(STALL_TIMEOUT);

  logic [NUM_REGS-1:0]    sb_q, sb_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   sb_error_q, sb_error_d;

  logic [NUM_SRC-1:0]     op_hazard;
  logic                   issue_acc;
  logic                   done_valid;

  hazard_scoreboard_if #(
    .NUM_SRC        (NUM_SRC),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .REG_ADDR_W     (REG_ADDR_W)
  ) hz_bus ();

  assign hz_bus.ex_rs          = ex_rs;
  assign hz_bus.ex_valid       = ex_valid;
  assign hz_bus.stg_dest       = stg_dest;
  assign hz_bus.stg_regwr      = stg_regwr;
  assign hz_bus.stg_data_valid = stg_data_valid;
  assign hz_bus.lat_done       = lat_done;
  assign hz_bus.lat_done_dest  = lat_done_dest;
  assign hz_bus.stall          = |op_hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_operand_sel #(
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .REG_ADDR_W     (REG_ADDR_W)
    ) u_sel (
      .rs             (hz_bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .ex_valid       (hz_bus.ex_valid),
      .stg_dest       (hz_bus.stg_dest),
      .stg_regwr      (hz_bus.stg_regwr),
      .stg_data_valid (hz_bus.stg_data_valid),
      .lat_done       (hz_bus.lat_done),
      .lat_done_dest  (hz_bus.lat_done_dest),
      .pending        (sb_q[hz_bus.ex_rs[i*REG_ADDR_W +: REG_ADDR_W]]),
      .sel            (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard         (op_hazard[i])
    );
  end

  assign stall = hz_bus.stall;

  // WAW check uses the pre-update scoreboard, so a register completing
  // this cycle still blocks a new issue to it.
  assign lat_issue_ready = ~stall
                         & (outstanding_q < OUT_MAX)
                         & ~sb_q[lat_issue_dest]
                         & (lat_issue_dest != '0);

  assign issue_acc  = lat_issue & lat_issue_ready;
  assign done_valid = lat_done & sb_q[lat_done_dest];

  always_comb begin
    sb_d = sb_q;
    if (done_valid) sb_d[lat_done_dest]  = 1'b0;
    if (issue_acc)  sb_d[lat_issue_dest] = 1'b1;

    outstanding_d = outstanding_q;
    if (issue_acc && !done_valid) outstanding_d = outstanding_q + OUT_W'(1);
    if (!issue_acc && done_valid) outstanding_d = outstanding_q - OUT_W'(1);

    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + STALL_CNT_W'(1);
    end

    timeout_d  = timeout_q | (stall_cnt_d >= TIMEOUT_CNT);
    sb_error_d = sb_error_q | (lat_done & ~sb_q[lat_done_dest]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sb_q          <= '0;
      outstanding_q <= '0;
      stall_cnt_q   <= '0;
      timeout_q     <= 1'b0;
      sb_error_q    <= 1'b0;
    end else begin
      sb_q          <= sb_d;
      outstanding_q <= outstanding_d;
      stall_cnt_q   <= stall_cnt_d;
      timeout_q     <= timeout_d;
      sb_error_q    <= sb_error_d;
    end
  end

  assign outstanding    = outstanding_q;
  assign hazard_timeout = timeout_q;
  assign sb_error       = sb_error_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  localparam int NS = 2;
  localparam int NF = 2;
  localparam int RW = 5;
  localparam int SW = 2;
  localparam int OW = 3;
  localparam int MAXO = 4;
  localparam int TMO = 200;
  localparam int CNT_MAX = 255;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [NS*RW-1:0] ex_rs = '0;
  logic           ex_valid = 1'b0;
  logic [NF*RW-1:0] stg_dest = '0;
  logic [NF-1:0]  stg_regwr = '0;
  logic [NF-1:0]  stg_data_valid = '0;
  logic           lat_issue = 1'b0;
  logic [RW-1:0]  lat_issue_dest = '0;
  logic           lat_issue_ready;
  logic           lat_done = 1'b0;
  logic [RW-1:0]  lat_done_dest = '0;
  logic [NS*SW-1:0] fwd_sel;
  logic           stall;
  logic [OW-1:0]  outstanding;
  logic           hazard_timeout;
  logic           sb_error;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  bit m_pend [32];
  int m_out = 0;
  int m_cnt = 0;
  bit m_to  = 0;
  bit m_err = 0;

  always #5 CLK = ~CLK;

  hazard_scoreboard_unit dut (
    .CLK            (CLK),
    .RST            (RST),
    .ex_rs          (ex_rs),
    .ex_valid       (ex_valid),
    .stg_dest       (stg_dest),
    .stg_regwr      (stg_regwr),
    .stg_data_valid (stg_data_valid),
    .lat_issue      (lat_issue),
    .lat_issue_dest (lat_issue_dest),
    .lat_issue_ready(lat_issue_ready),
    .lat_done       (lat_done),
    .lat_done_dest  (lat_done_dest),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .outstanding    (outstanding),
    .hazard_timeout (hazard_timeout),
    .sb_error       (sb_error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // What each operand must select / whether it blocks, straight from the rules.
  function automatic int m_sel(int i);
    int rs = int'(ex_rs[i*RW +: RW]);
    if (!ex_valid || rs == 0) return 0;
    for (int k = 0; k < NF; k++)
      if (stg_regwr[k] && int'(stg_dest[k*RW +: RW]) == rs) return k + 1;
    if (lat_done && int'(lat_done_dest) == rs) return NF + 1;
    return 0;
  endfunction

  function automatic bit m_haz(int i);
    int rs = int'(ex_rs[i*RW +: RW]);
    if (!ex_valid || rs == 0) return 0;
    for (int k = 0; k < NF; k++)
      if (stg_regwr[k] && int'(stg_dest[k*RW +: RW]) == rs) return !stg_data_valid[k];
    if (lat_done && int'(lat_done_dest) == rs) return 0;
    return m_pend[rs];
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    for (int i = 0; i < NS; i++) s |= m_haz(i);
    return s;
  endfunction

  function automatic bit m_ready();
    return !m_stall() && (m_out < MAXO) && !m_pend[lat_issue_dest] && (lat_issue_dest != 0);
  endfunction

  function automatic logic [31:0] m_fwd();
    logic [31:0] v = 0;
    for (int i = 0; i < NS; i++) v |= (m_sel(i) << (i*SW));
    return v;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < 32; r++) m_pend[r] = 0;
      m_out = 0; m_cnt = 0; m_to = 0; m_err = 0;
    end else begin
      bit s, acc, dv;
      s   = m_stall();
      acc = lat_issue && m_ready();
      dv  = lat_done && m_pend[lat_done_dest];
      if (lat_done && !dv) m_err = 1;
      if (dv)  m_pend[lat_done_dest]  = 0;
      if (acc) m_pend[lat_issue_dest] = 1;
      m_out = m_out + int'(acc) - int'(dv);
      m_cnt = s ? ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX) : 0;
      if (m_cnt >= TMO) m_to = 1;
    end
  end

  always @(negedge CLK) begin
    chk("fwd_sel",         32'(fwd_sel),         m_fwd());
    chk("stall",           32'(stall),           32'(m_stall()));
    chk("lat_issue_ready", 32'(lat_issue_ready), 32'(m_ready()));
    chk("outstanding",     32'(outstanding),     32'(m_out));
    chk("hazard_timeout",  32'(hazard_timeout),  32'(m_to));
    chk("sb_error",        32'(sb_error),        32'(m_err));
  end

  task automatic next();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #1 RST = 1'b1;
    repeat (2) next();
    RST = 1'b0;

    // Reset state with quiet inputs
    ex_valid = 1'b1; ex_rs = {5'd4, 5'd3};
    settle();
    chk("pin_reset_fwd", 32'(fwd_sel), 32'd0);
    chk("pin_reset_stall", 32'(stall), 32'd0);
    chk("pin_reset_out", 32'(outstanding), 32'd0);
    next();

    // Youngest stage priority, fall-through to older stage, x0
    stg_dest = {5'd3, 5'd3}; stg_regwr = 2'b11; stg_data_valid = 2'b11;
    settle(); chk("pin_exmem_prio", 32'(fwd_sel), 32'b0001); next();
    stg_regwr = 2'b10;
    settle(); chk("pin_memwb", 32'(fwd_sel), 32'b0010); next();
    ex_rs = {5'd4, 5'd0}; stg_dest = {5'd3, 5'd0}; stg_regwr = 2'b11;
    settle(); chk("pin_x0", 32'(fwd_sel), 32'd0); next();

    // Load-use
    ex_rs = {5'd5, 5'd0}; stg_dest = {5'd0, 5'd5}; stg_regwr = 2'b01; stg_data_valid = 2'b00;
    settle();
    chk("pin_loaduse_stall", 32'(stall), 32'd1);
    chk("pin_loaduse_sel", 32'(fwd_sel), 32'b0100);
    next();
    stg_data_valid = 2'b01;
    settle(); chk("pin_loaduse_clear", 32'(stall), 32'd0); next();

    // Long-latency issue, pending stall, completion forwarding
    stg_regwr = 2'b00; ex_rs = {5'd4, 5'd3};
    lat_issue = 1'b1; lat_issue_dest = 5'd7;
    settle(); chk("pin_issue7_ready", 32'(lat_issue_ready), 32'd1); next();
    lat_issue = 1'b0; ex_rs = {5'd4, 5'd7};
    for (int c = 0; c < 3; c++) begin
      settle(); chk("pin_pending_stall", 32'(stall), 32'd1); next();
    end
    chk("pin_out1", 32'(outstanding), 32'd1);
    lat_done = 1'b1; lat_done_dest = 5'd7;
    settle();
    chk("pin_lat_fwd", 32'(fwd_sel), 32'b0011);
    chk("pin_lat_nostall", 32'(stall), 32'd0);
    next();
    lat_done = 1'b0;
    settle(); chk("pin_out0", 32'(outstanding), 32'd0); next();

    // Fill to capacity, WAW reject, simultaneous issue + done
    ex_valid = 1'b0;
    for (int r = 8; r <= 11; r++) begin
      lat_issue = 1'b1; lat_issue_dest = 5'(r);
      settle(); chk("pin_fill_ready", 32'(lat_issue_ready), 32'd1); next();
    end
    lat_issue_dest = 5'd13;
    settle();
    chk("pin_full_out", 32'(outstanding), 32'd4);
    chk("pin_full_ready", 32'(lat_issue_ready), 32'd0);
    next();
    lat_done = 1'b1; lat_done_dest = 5'd8; lat_issue_dest = 5'd12;
    settle(); chk("pin_full_done_ready", 32'(lat_issue_ready), 32'd0); next();
    lat_done = 1'b0; lat_issue_dest = 5'd10;
    settle();
    chk("pin_out3", 32'(outstanding), 32'd3);
    chk("pin_waw_ready", 32'(lat_issue_ready), 32'd0);
    next();
    lat_done = 1'b1; lat_done_dest = 5'd9; lat_issue_dest = 5'd12;
    settle(); chk("pin_swap_ready", 32'(lat_issue_ready), 32'd1); next();
    lat_issue = 1'b0; lat_done = 1'b0;
    settle(); chk("pin_swap_out", 32'(outstanding), 32'd3); next();

    // Completion for a register never issued
    lat_done = 1'b1; lat_done_dest = 5'd20;
    next();
    lat_done = 1'b0;
    settle(); chk("pin_sb_error", 32'(sb_error), 32'd1); next();
    settle(); chk("pin_sb_error_sticky", 32'(sb_error), 32'd1); next();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int np;
      int pick;
      ex_valid       = ($urandom_range(0, 3) != 0);
      ex_rs          = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      stg_dest       = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      stg_regwr      = 2'($urandom_range(0, 3));
      stg_data_valid = 2'($urandom_range(0, 3));
      lat_issue      = ($urandom_range(0, 2) == 0);
      lat_issue_dest = 5'($urandom_range(0, 15));
      lat_done       = 1'b0;
      np = 0;
      for (int r = 0; r < 32; r++) np += int'(m_pend[r]);
      if (np > 0 && $urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, np - 1);
        for (int r = 0; r < 32; r++) begin
          if (m_pend[r]) begin
            if (pick == 0) begin lat_done = 1'b1; lat_done_dest = 5'(r); end
            pick--;
          end
        end
      end else if ($urandom_range(0, 19) == 0) begin
        lat_done = 1'b1; lat_done_dest = 5'($urandom_range(0, 31));
      end
      next();
    end

    // Drain all outstanding ops
    lat_issue = 1'b0; ex_valid = 1'b0; stg_regwr = 2'b00;
    for (int r = 0; r < 32; r++) begin
      if (m_pend[r]) begin
        lat_done = 1'b1; lat_done_dest = 5'(r); next();
      end
    end
    lat_done = 1'b0;
    next();
    chk("pin_drained", 32'(outstanding), 32'd0);

    // Timeout: hold a pending-register hazard
    if (hazard_timeout !== 1'b0) chk("pre_timeout_clear", 32'(hazard_timeout), 32'd0);
    ex_valid = 1'b1; ex_rs = {5'd0, 5'd0};
    lat_issue = 1'b1; lat_issue_dest = 5'd7;
    settle(); chk("pin_to_issue", 32'(lat_issue_ready), 32'd1); next();
    lat_issue = 1'b0; ex_rs = {5'd0, 5'd7};
    repeat (199) next();
    chk("pin_timeout_199", 32'(hazard_timeout), 32'd0);
    next();
    chk("pin_timeout_200", 32'(hazard_timeout), 32'd1);
    next();
    chk("pin_timeout_sticky", 32'(hazard_timeout), 32'd1);

    // Reset mid-flight
    RST = 1'b1;
    settle();
    chk("pin_rst_out", 32'(outstanding), 32'd0);
    chk("pin_rst_timeout", 32'(hazard_timeout), 32'd0);
    chk("pin_rst_sb_error", 32'(sb_error), 32'd0);
    chk("pin_rst_stall", 32'(stall), 32'd0);
    chk("pin_rst_fwd", 32'(fwd_sel), 32'd0);
    next();
    RST = 1'b0;
    next();
    lat_done = 1'b1; lat_done_dest = 5'd7;
    next();
    lat_done = 1'b0;
    settle(); chk("pin_stale_done", 32'(sb_error), 32'd1);
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
